// File: rtl/data_cache.sv
// data_cache
//
// Direct-mapped, write-back data cache of 8 blocks x 4 bytes. It sits between
// the CPU byte load/store path and a block-organised data memory.
//
// Read hits are answered combinationally. Write hits update the block at the
// clock edge. A miss stalls the CPU through busywait. It writes back a dirty
// victim block first, then fetches the new block, then installs it in an
// UPDATE cycle. After that the request is served as an ordinary hit.
//
// Ports
//   clock          : single clock, rising edge
//   reset          : synchronous, active-low reset
//   read, write    : CPU byte request strobes (both high = ignored)
//   address[7:0]   : CPU byte address  {tag[7:5], index[4:2], offset[1:0]}
//   writedata[7:0] : CPU write byte
//   readdata[7:0]  : CPU read byte (8'h00 unless this is an IDLE read hit)
//   busywait       : CPU stall
//   mem_read       : block fetch request to the data memory
//   mem_write      : block write-back request to the data memory
//   mem_address    : block address {tag, index}
//   mem_writedata  : victim block, byte k at [8k+7:8k]
//   mem_readdata   : fetched block, same byte order
//   mem_busywait   : memory busy, falls when the transfer completes
module data_cache (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  // High during the first cycle spent in a state. A memory transfer may only
  // complete after the strobe has been presented for at least one full cycle.
  logic        state_entry_reg;
  logic [31:0] fetch_buf_reg;

  logic [2:0]  addr_tag;
  logic [2:0]  addr_index;
  logic [1:0]  addr_offset;
  logic [4:0]  byte_lsb;

  logic [7:0]  valid_vec;
  logic [7:0]  dirty_vec;
  logic [2:0]  tag_arr  [8];
  logic [31:0] data_arr [8];

  logic [2:0]  sel_tag;
  logic [31:0] sel_block;
  logic        access;
  logic        hit;
  logic        victim_dirty;
  logic        fill_en;
  logic        hit_write_en;
  logic        xfer_done;

  assign addr_tag    = address[7:5];
  assign addr_index  = address[4:2];
  assign addr_offset = address[1:0];
  assign byte_lsb    = {addr_offset, 3'b000};

  assign sel_tag      = tag_arr[addr_index];
  assign sel_block    = data_arr[addr_index];
  // read and write together is illegal and is treated as no request.
  assign access       = read ^ write;
  assign hit          = valid_vec[addr_index] && (sel_tag == addr_tag);
  assign victim_dirty = valid_vec[addr_index] && dirty_vec[addr_index];
  assign fill_en      = (state_reg == UPDATE);
  assign hit_write_en = (state_reg == IDLE) && write && !read && hit;
  assign xfer_done    = !state_entry_reg && !mem_busywait;

  // One storage entry per index.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_entry
      logic        valid_reg;
      logic        dirty_reg;
      logic [2:0]  tag_reg;
      logic [31:0] data_reg;
      logic        sel;

      assign sel = (addr_index == 3'(gi));

      always_ff @(posedge clock) begin
        if (!reset) begin
          valid_reg <= 1'b0;
          dirty_reg <= 1'b0;
        end else if (sel && fill_en) begin
          valid_reg <= 1'b1;
          dirty_reg <= 1'b0;
        end else if (sel && hit_write_en) begin
          dirty_reg <= 1'b1;
        end
      end

      // Tag and data only matter while valid, so they carry no reset.
      always_ff @(posedge clock) begin
        if (sel && fill_en) begin
          tag_reg  <= addr_tag;
          data_reg <= fetch_buf_reg;
        end else if (sel && hit_write_en) begin
          data_reg[byte_lsb +: 8] <= writedata;
        end
      end

      assign valid_vec[gi] = valid_reg;
      assign dirty_vec[gi] = dirty_reg;
      assign tag_arr[gi]   = tag_reg;
      assign data_arr[gi]  = data_reg;
    end
  endgenerate

  // State register and fetch capture.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg       <= IDLE;
      state_entry_reg <= 1'b0;
      fetch_buf_reg   <= 32'h0;
    end else begin
      state_reg       <= state_next;
      state_entry_reg <= (state_next != state_reg);
      if ((state_reg == FETCH) && (state_next == UPDATE)) begin
        fetch_buf_reg <= mem_readdata;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (access && !hit) begin
          state_next = victim_dirty ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        if (xfer_done) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (xfer_done) begin
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    readdata      = 8'h00;
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = 6'h00;
    mem_writedata = 32'h0;
    case (state_reg)
      IDLE: begin
        if (access && !hit) begin
          busywait = 1'b1;
        end else if (read && !write && hit) begin
          readdata = sel_block[byte_lsb +: 8];
        end
      end
      WRITEBACK: begin
        busywait      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {sel_tag, addr_index};
        mem_writedata = sel_block;
      end
      FETCH: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {addr_tag, addr_index};
      end
      UPDATE: begin
        busywait = 1'b1;
      end
      default: begin
        busywait = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache
//
// Bench for data_cache. It provides a behavioural block memory with an
// adjustable latency. It runs a table of directed vectors, a reset taken in
// the middle of a fetch, a fill of every index, and random traffic.
//
// The reference model treats the cache as transparent byte storage. A read
// must return the last byte written to that address. It also tracks
// direct-mapped residency, which fixes the stall count and memory traffic
// expected for each access.
module tb_data_cache;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  data_cache dut (
    .clock         (clock),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // ---------------- block memory model ----------------
  logic [31:0] mem_store    [64];
  logic [31:0] init_pattern [64];
  int          mem_cnt;
  int          mem_lat;
  int          wb_count = 0;
  int          rd_count = 0;
  logic [5:0]  last_wb_addr;
  logic [31:0] last_wb_data;
  logic [5:0]  last_rd_addr;
  int          overlap_cnt = 0;

  assign mem_busywait = (mem_read || mem_write) && (mem_cnt < mem_lat);
  assign mem_readdata = mem_store[mem_address];

  always @(posedge clock) begin
    if (!reset) begin
      mem_cnt <= 0;
      for (int b = 0; b < 64; b++) mem_store[b] <= init_pattern[b];
    end else if (mem_read || mem_write) begin
      if (mem_cnt < mem_lat) begin
        mem_cnt <= mem_cnt + 1;
      end else begin
        mem_cnt <= 0;
        if (mem_write) begin
          mem_store[mem_address] <= mem_writedata;
          wb_count     <= wb_count + 1;
          last_wb_addr <= mem_address;
          last_wb_data <= mem_writedata;
        end else begin
          rd_count     <= rd_count + 1;
          last_rd_addr <= mem_address;
        end
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  always @(negedge clock) begin
    if (mem_read && mem_write) overlap_cnt <= overlap_cnt + 1;
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_bytes [256];
  bit         m_valid   [8];
  bit         m_dirty   [8];
  logic [2:0] m_tag     [8];

  task automatic model_reset();
    logic [31:0] w;
    for (int a = 0; a < 256; a++) begin
      w = init_pattern[a / 4];
      ref_bytes[a] = w[8 * (a % 4) +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 3'd0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input bit check_outputs);
    read = 1'b0;
    write = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    if (check_outputs) begin
      @(negedge clock);
      chk("rst_busywait", {31'd0, busywait}, 32'd0);
      chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
      chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
      chk("rst_readdata", {24'd0, readdata}, 32'd0);
      chk("rst_mem_address", {26'd0, mem_address}, 32'd0);
      chk("rst_mem_writedata", mem_writedata, 32'd0);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
  endtask

  // Presents one request, called at posedge+1. Holds it until busywait is
  // low and returns after the completing edge (again at posedge+1).
  task automatic run_access(input logic rd, input logic wr, input logic [7:0] a,
                            input logic [7:0] wd, output logic [7:0] rdata,
                            output int stalls, output int wbs, output int fetches);
    int  wb0;
    int  f0;
    bit  done;
    wb0 = wb_count;
    f0 = rd_count;
    done = 1'b0;
    stalls = 0;
    rdata = 8'h00;
    read = rd;
    write = wr;
    address = a;
    writedata = wd;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (!busywait) begin
        rdata = readdata;
        done = 1'b1;
        break;
      end
      stalls++;
    end
    if (!done) chk("timeout_busywait", 32'd1, 32'd0);
    @(posedge clock); #1;
    read = 1'b0;
    write = 1'b0;
    wbs = wb_count - wb0;
    fetches = rd_count - f0;
    $display("txn rd=%0d wr=%0d addr=%02h wd=%02h rdata=%02h stalls=%0d wb=%0d fetch=%0d",
             rd, wr, a, wd, rdata, stalls, wbs, fetches);
  endtask

  // Access checked against the reference model.
  task automatic check_access(input logic rd, input logic wr, input logic [7:0] a,
                              input logic [7:0] wd);
    int         idx;
    int         base;
    bit         legal;
    bit         is_hit;
    bit         miss;
    bit         vict_dirty;
    int         exp_stalls;
    logic [7:0] exp_rdata;
    logic [31:0] exp_wb_data;
    logic [7:0] got;
    int         stalls;
    int         wbs;
    int         fetches;
    idx = int'(a[4:2]);
    legal = rd ^ wr;
    is_hit = m_valid[idx] && (m_tag[idx] == a[7:5]);
    miss = legal && !is_hit;
    vict_dirty = m_valid[idx] && m_dirty[idx];
    exp_stalls = miss ? (1 + (mem_lat + 1) + 1 + (vict_dirty ? mem_lat + 1 : 0)) : 0;
    exp_rdata = (legal && rd) ? ref_bytes[a] : 8'h00;
    base = int'(m_tag[idx]) * 32 + idx * 4;
    exp_wb_data = {ref_bytes[base + 3], ref_bytes[base + 2], ref_bytes[base + 1], ref_bytes[base]};
    run_access(rd, wr, a, wd, got, stalls, wbs, fetches);
    chk("rnd_readdata", {24'd0, got}, {24'd0, exp_rdata});
    chk("rnd_stalls", stalls, exp_stalls);
    chk("rnd_writebacks", wbs, (miss && vict_dirty) ? 1 : 0);
    chk("rnd_fetches", fetches, miss ? 1 : 0);
    if (miss && vict_dirty) begin
      chk("rnd_wb_addr", {26'd0, last_wb_addr}, 32'(base / 4));
      chk("rnd_wb_data", last_wb_data, exp_wb_data);
    end
    if (miss) chk("rnd_fetch_addr", {26'd0, last_rd_addr}, {26'd0, a[7:2]});
    if (miss) begin
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx] = a[7:5];
    end
    if (legal && wr) begin
      ref_bytes[a] = wd;
      m_dirty[idx] = 1'b1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wd;
    logic [7:0]  exp_rdata;
    int          exp_stalls;
    int          exp_wb;
    int          exp_fetch;
    logic [5:0]  exp_wb_addr;
    logic [31:0] exp_wb_data;
    logic [5:0]  exp_rd_addr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [7:0] got;
    int stalls;
    int wbs;
    int fetches;

    reset = 1'b0;
    read = 1'b0;
    write = 1'b0;
    address = 8'h00;
    writedata = 8'h00;
    mem_lat = 2;
    for (int b = 0; b < 64; b++) init_pattern[b] = $urandom;
    init_pattern[9]  = 32'hDDCCBBAA;
    init_pattern[17] = 32'h44332211;

    // Memory latency 2: each transfer takes 3 cycles in its state.
    vecs[0] = '{1'b1, 1'b0, 8'h24, 8'h00, 8'hAA, 5, 0, 1, 6'd0, 32'h0, 6'd9};
    vecs[1] = '{1'b1, 1'b0, 8'h27, 8'h00, 8'hDD, 0, 0, 0, 6'd0, 32'h0, 6'd0};
    vecs[2] = '{1'b0, 1'b1, 8'h25, 8'h55, 8'h00, 0, 0, 0, 6'd0, 32'h0, 6'd0};
    vecs[3] = '{1'b1, 1'b0, 8'h25, 8'h00, 8'h55, 0, 0, 0, 6'd0, 32'h0, 6'd0};
    vecs[4] = '{1'b1, 1'b0, 8'h45, 8'h00, 8'h22, 8, 1, 1, 6'd9, 32'hDDCC55AA, 6'd17};
    vecs[5] = '{1'b1, 1'b1, 8'h45, 8'h99, 8'h00, 0, 0, 0, 6'd0, 32'h0, 6'd0};
    vecs[6] = '{1'b1, 1'b0, 8'h45, 8'h00, 8'h22, 0, 0, 0, 6'd0, 32'h0, 6'd0};
    vecs[7] = '{1'b1, 1'b0, 8'h24, 8'h00, 8'hAA, 5, 0, 1, 6'd0, 32'h0, 6'd9};
    vecs[8] = '{1'b1, 1'b0, 8'h25, 8'h00, 8'h55, 0, 0, 0, 6'd0, 32'h0, 6'd0};

    do_reset(1'b1);

    for (int i = 0; i < 9; i++) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, got, stalls, wbs, fetches);
      chk($sformatf("vec%0d_readdata", i), {24'd0, got}, {24'd0, vecs[i].exp_rdata});
      chk($sformatf("vec%0d_stalls", i), stalls, vecs[i].exp_stalls);
      chk($sformatf("vec%0d_writebacks", i), wbs, vecs[i].exp_wb);
      chk($sformatf("vec%0d_fetches", i), fetches, vecs[i].exp_fetch);
      if (vecs[i].exp_wb != 0) begin
        chk($sformatf("vec%0d_wb_addr", i), {26'd0, last_wb_addr}, {26'd0, vecs[i].exp_wb_addr});
        chk($sformatf("vec%0d_wb_data", i), last_wb_data, vecs[i].exp_wb_data);
      end
      if (vecs[i].exp_fetch != 0) begin
        chk($sformatf("vec%0d_fetch_addr", i), {26'd0, last_rd_addr}, {26'd0, vecs[i].exp_rd_addr});
      end
    end

    // Reset taken in the middle of a fetch.
    do_reset(1'b0);
    mem_lat = 3;
    read = 1'b1;
    address = 8'h30;
    @(negedge clock);
    @(negedge clock);
    chk("midfetch_mem_read_active", {31'd0, mem_read}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    read = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("midfetch_mem_read_dropped", {31'd0, mem_read}, 32'd0);
    chk("midfetch_busywait_dropped", {31'd0, busywait}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    check_access(1'b1, 1'b0, 8'h30, 8'h00);

    // Fill every index, then reread: 8 misses followed by 8 hits.
    do_reset(1'b0);
    mem_lat = 1;
    for (int i = 0; i < 8; i++) check_access(1'b1, 1'b0, 8'(i * 4), 8'h00);
    for (int i = 0; i < 8; i++) check_access(1'b1, 1'b0, 8'(i * 4 + 1), 8'h00);

    // Random traffic over a few tags so hits, clean and dirty misses mix.
    for (int b = 0; b < 64; b++) init_pattern[b] = $urandom;
    do_reset(1'b0);
    for (int n = 0; n < 150; n++) begin
      logic [7:0] a;
      logic       rd;
      logic       wr;
      int         op;
      mem_lat = $urandom_range(1, 3);
      a = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 9);
      rd = (op < 5) || (op == 9);
      wr = (op >= 5);
      check_access(rd, wr, a, 8'($urandom));
    end

    chk("strobe_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back data cache between the CPU load/store path and the 256x8 block-organised data memory. It serves byte reads and writes from an 8-entry, 4-byte-block store. On a miss it initiates block transfers on the memory's read/write/busywait handshake: a write-back of a dirty victim, then a fetch. While a miss is being serviced, the CPU is stalled through `busywait`.

## Interface
- No parameters: geometry is fixed at 8 blocks x 4 bytes, 8-bit CPU address, 6-bit block address.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `read` in 1: CPU byte-read request, held until `busywait` is low at a rising edge.
- `write` in 1: CPU byte-write request, held the same way.
- `address` in 8: CPU byte address; tag = [7:5], index = [4:2], offset = [1:0].
- `writedata` in 8: CPU write byte.
- `readdata` out 8: CPU read byte.
- `busywait` out 1: stall to the CPU.
- `mem_read` out 1: block fetch request to the data memory.
- `mem_write` out 1: block write-back request to the data memory.
- `mem_address` out 6: block address {tag, index}.
- `mem_writedata` out 32: victim block; byte k sits at [8k+7:8k].
- `mem_readdata` in 32: fetched block, same byte order.
- `mem_busywait` in 1: memory busy; it rises combinationally with `mem_read` or `mem_write` and falls when the transfer is complete.

## Operation
- Per entry: valid (1), dirty (1), tag (3), data (32). The entry is selected by `index`. A hit is valid AND (stored tag == `address[7:5]`).
- An access is `read` XOR `write`. `read` && `write` together is illegal: it is ignored, `busywait` = 0, and no state changes.
- FSM states and transitions:
  - IDLE
    - Hit read: `readdata` = data byte[offset] combinationally; `busywait` = 0.
    - Hit write: at the edge, byte[offset] <= `writedata` and dirty <= 1; `busywait` = 0.
    - Miss, clean or invalid victim: `busywait` = 1; go to FETCH.
    - Miss, dirty victim: `busywait` = 1; go to WRITEBACK.
  - WRITEBACK
    - `mem_write` = 1, `mem_address` = {stored tag, index}, `mem_writedata` = stored block.
    - At an edge with `mem_busywait` == 0 and `mem_write` asserted during the preceding cycle, go to FETCH.
  - FETCH
    - `mem_read` = 1, `mem_address` = {`address[7:5]`, index}.
    - At an edge with `mem_busywait` == 0 after at least one cycle in FETCH, go to UPDATE.
    - The fetched block is captured from `mem_readdata` on that edge.
  - UPDATE
    - One cycle; `mem_read` = `mem_write` = 0.
    - At the edge: data <= captured block, tag <= `address[7:5]`, valid <= 1, dirty <= 0; go to IDLE.
    - The access then re-evaluates as a hit: a read returns the fetched byte, a write merges its byte and sets dirty.
- `busywait` = 1 in WRITEBACK, FETCH and UPDATE, and in IDLE on a miss. It is 0 otherwise.
- `mem_read` and `mem_write` are never both 1.
- `readdata` = 8'h00 when the current cycle is not an IDLE read hit.

## Timing
- Reset values (when `reset` is low at an edge): all valid = 0, all dirty = 0, state = IDLE. Outputs `busywait`, `mem_read`, `mem_write` = 0; `readdata` = 8'h00; `mem_address` = 0; `mem_writedata` = 0.
- Reset mid-miss: the transfer is abandoned and strobes are low from the next cycle. A dirty block is lost, and the memory must be reset with the cache.
- Hit latency: 0 stall cycles. The CPU completes at the first rising edge.
- Clean miss: 1 (IDLE detect) + memory fetch cycles + 1 (UPDATE) stall cycles, then the hit.
- Dirty miss: adds the write-back cycles before the fetch.
- Request addresses, data and strobes are stable for the entire time the memory's `mem_busywait` is high.
- Requests are never dropped on their own. The CPU must hold `read`, `write`, `address` and `writedata` while `busywait` = 1; changing them mid-miss is illegal.

## Test plan
- Reset, then read 0x24 (tag 1, index 1) with memory block 9 = 0xDDCCBBAA -> `busywait` high, `mem_read` with `mem_address` = 9. After UPDATE, `readdata` = 0xAA and `busywait` low; a repeat read of 0x27 returns 0xDD with zero stall.
- Write 0x55 to 0x25 after that fill -> no memory traffic; the entry becomes dirty with block 0xDDCC55AA.
- Read 0x45 (same index, tag 2) with entry 1 dirty -> `mem_write` to address 9 with data 0xDDCC55AA, then `mem_read` to address 17. `mem_read` and `mem_write` never overlap.
- `read` and `write` both high -> `busywait` stays 0, no memory strobes, no state change.
- `reset` driven low during FETCH -> `mem_read` and `busywait` are 0 from the next cycle; a subsequent read of the same address misses.
- Fill all 8 indices with reads (address stride 4), then reread each -> 8 misses, then 8 zero-stall hits.
